// File: rtl/jt1942_pkg.sv
// Shared definitions for the JT1942 scroll tile ROM fetch path.
// Contents:
//   scr_state_t      - fetch FSM state encoding
//   WORDS_PER_ENTRY  - SDRAM words per scroll ROM entry
//   entry_word_addr  - SDRAM word address of one word of an entry
package jt1942_pkg;

  localparam int SCR_AW          = 14;  // scroll ROM entry address width
  localparam int SDRAM_AW        = 22;  // SDRAM word address width
  localparam int SDRAM_DW        = 16;  // SDRAM data width
  localparam int ENTRY_W         = 24;  // {z,y,x} plane bytes
  localparam int WORDS_PER_ENTRY = 2;
  localparam int WORD_SEL_W      = $clog2(WORDS_PER_ENTRY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_DONE
  } scr_state_t;

  // base + entry*2 + word, wrapping modulo 2^SDRAM_AW.
  function automatic logic [SDRAM_AW-1:0] entry_word_addr(
    input logic [SDRAM_AW-1:0]   base,
    input logic [SCR_AW-1:0]     entry,
    input logic [WORD_SEL_W-1:0] word
  );
    return base + {{(SDRAM_AW-SCR_AW-WORD_SEL_W){1'b0}}, entry, word};
  endfunction

endpackage

// File: rtl/jt1942_scrom_fetch.sv
// Scroll tile ROM fetcher: keeps one cached {z,y,x} entry for the scroll
// generator and refills it from SDRAM (two 16-bit words per entry) on a miss.
// Ports:
//   clk, rst            - system clock, async active-high reset
//   scr_addr            - entry address requested by the scroll generator
//   scrom_data, data_ok - cached entry and "matches scr_addr right now"
//   sdram_req/addr      - level request to the arbiter, held until ack
//   sdram_ack/dst/din   - arbiter accept pulse, data strobe and read word
//   timeout_err         - sticky, set whenever an ack did not arrive in time
module jt1942_scrom_fetch
  import jt1942_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] ROM_OFFSET = 22'h0,
  parameter logic [5:0]          TIMEOUT    = 6'd48
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [SCR_AW-1:0]   scr_addr,
  output logic [ENTRY_W-1:0]  scrom_data,
  output logic                data_ok,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_dst,
  input  logic [SDRAM_DW-1:0] sdram_din,
  output logic                timeout_err
);

  localparam logic [5:0] TMO_LAST = TIMEOUT - 6'd1;

  scr_state_t        state, state_nx;
  logic [SCR_AW-1:0] tag, pend_addr;
  logic              tag_valid;
  logic [15:0]       stage_lo;
  logic [7:0]        stage_hi;
  logic [5:0]        tmo_cnt;
  logic              backoff;   // one-clk request gap after a timeout
  logic              miss, stale, in_req;
  logic              start, next_word, cap_lo, cap_hi, commit, expire;

  assign miss      = !tag_valid || (scr_addr != tag);
  assign stale     = scr_addr != pend_addr;
  assign in_req    = (state == ST_REQ0) || (state == ST_REQ1);
  assign sdram_req = in_req && !backoff;
  assign data_ok   = tag_valid && (tag == scr_addr) && (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    next_word = 1'b0;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
    commit    = 1'b0;
    expire    = 1'b0;
    unique case (state)
      ST_IDLE: if (miss) begin
        start    = 1'b1;
        state_nx = ST_REQ0;
      end
      // ack+dst together counts as ack followed by dst
      ST_REQ0: if (!backoff) begin
        if (sdram_ack && sdram_dst)  cap_lo   = 1'b1;
        else if (sdram_ack)          state_nx = ST_WAIT0;
        else if (tmo_cnt == TMO_LAST) expire  = 1'b1;
      end
      ST_WAIT0: if (sdram_dst) cap_lo = 1'b1;
      ST_REQ1: if (!backoff) begin
        if (sdram_ack && sdram_dst)  cap_hi   = 1'b1;
        else if (sdram_ack)          state_nx = ST_WAIT1;
        else if (tmo_cnt == TMO_LAST) expire  = 1'b1;
      end
      ST_WAIT1: if (sdram_dst) cap_hi = 1'b1;
      ST_DONE: begin
        commit   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // A word only lands once its transaction is fully consumed, so this is
    // the only safe point to drop a fetch whose address went stale.
    if (cap_lo || cap_hi) begin
      if (stale) begin
        start    = 1'b1;
        state_nx = ST_REQ0;
      end else if (cap_lo) begin
        next_word = 1'b1;
        state_nx  = ST_REQ1;
      end else begin
        state_nx  = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_addr   <= '0;
      sdram_addr  <= '0;
      stage_lo    <= '0;
      stage_hi    <= '0;
      scrom_data  <= '0;
      tag         <= '0;
      tag_valid   <= 1'b0;
      tmo_cnt     <= '0;
      backoff     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      backoff <= expire;
      if (expire) timeout_err <= 1'b1;
      if (start || next_word || expire)  tmo_cnt <= '0;
      else if (sdram_req && !sdram_ack)  tmo_cnt <= tmo_cnt + 6'd1;
      if (start) begin
        pend_addr  <= scr_addr;
        sdram_addr <= entry_word_addr(ROM_OFFSET, scr_addr, 1'b0);
      end
      if (next_word) sdram_addr <= entry_word_addr(ROM_OFFSET, pend_addr, 1'b1);
      if (cap_lo)    stage_lo   <= sdram_din;
      if (cap_hi)    stage_hi   <= sdram_din[7:0];
      // whole entry swaps in one edge, never half old / half new
      if (commit) begin
        scrom_data <= {stage_hi, stage_lo};
        tag        <= pend_addr;
        tag_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jt1942_scrom_fetch.sv
// Bench for jt1942_scrom_fetch: SDRAM responder with programmable ack/dst
// delays, table of single fills, directed corner sequences and a random
// address walk checked against a ROM model.
module tb_jt1942_scrom_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] scr_addr;
  logic [23:0] scrom_data;
  logic        data_ok, sdram_req, sdram_ack, sdram_dst, timeout_err;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_din;

  logic [13:0] w_scr;
  logic [23:0] w_data;
  logic        w_ok, w_req, w_ack, w_dst, w_err;
  logic [21:0] w_addr;
  logic [15:0] w_din;

  int nvec, nmis, cyc, nhigh, nbad, ack_dly, dst_dly, ph, r_cnt;
  logic        saw_old;
  logic [21:0] r_a;
  logic [21:0] acked[$];

  always #21 clk = ~clk;

  jt1942_scrom_fetch u_dut (
    .clk(clk), .rst(rst), .scr_addr(scr_addr), .scrom_data(scrom_data),
    .data_ok(data_ok), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .sdram_din(sdram_din),
    .timeout_err(timeout_err)
  );

  jt1942_scrom_fetch #(.ROM_OFFSET(22'h3FFFFE)) u_wrap (
    .clk(clk), .rst(rst), .scr_addr(w_scr), .scrom_data(w_data),
    .data_ok(w_ok), .sdram_req(w_req), .sdram_addr(w_addr),
    .sdram_ack(w_ack), .sdram_dst(w_dst), .sdram_din(w_din),
    .timeout_err(w_err)
  );

  function automatic logic [15:0] rom(input logic [21:0] a);
    logic [31:0] h;
    if (a == 22'h246) return 16'hA55A;
    if (a == 22'h247) return 16'h00C3;
    h = 32'(a) * 32'h9E3779B1;
    return h[31:16] ^ 16'h1234;
  endfunction

  // expected entry contents for the ROM_OFFSET=0 instance
  function automatic logic [23:0] entry(input logic [13:0] e);
    logic [21:0] a;
    logic [15:0] w0, w1;
    a  = 22'(e) * 22'd2;
    w0 = rom(a);
    w1 = rom(a + 22'd1);
    return {w1[7:0], w0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ok(input int lim);
    cyc = 0;
    while (!data_ok && cyc < lim) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_wreq(input string nm);
    int c;
    c = 0;
    do begin @(negedge clk); c++; end while (!w_req && c < 120);
    chk(nm, w_req, 1);
  endtask

  // SDRAM arbiter model: ack after ack_dly clks of request, dst dst_dly clks
  // after ack (0 = same clk); all pending work dropped on reset.
  initial begin
    ph = 0; r_cnt = 0; r_a = '0;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_din = '0;
    forever begin
      @(negedge clk);
      sdram_ack = 1'b0;
      sdram_dst = 1'b0;
      if (rst) ph = 0;
      else begin
        if (ph == 0 && sdram_req) begin
          r_a = sdram_addr; r_cnt = ack_dly; ph = 1;
        end
        if (ph == 1) begin
          if (r_cnt == 0 && sdram_req) begin
            sdram_ack = 1'b1;
            acked.push_back(r_a);
            if (dst_dly == 0) begin
              sdram_dst = 1'b1; sdram_din = rom(r_a); ph = 0;
            end else begin
              r_cnt = dst_dly; ph = 2;
            end
          end else if (r_cnt > 0) r_cnt--;
        end else if (ph == 2) begin
          r_cnt--;
          if (r_cnt == 0) begin
            sdram_dst = 1'b1; sdram_din = rom(r_a); ph = 0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [13:0] a;
    int          ad;
    int          dd;
    logic        fetch;
    logic [21:0] w0;
    int          maxlat;
    logic [23:0] d;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [13:0] pool[6];
    logic [15:0] r0, r1;
    nvec = 0; nmis = 0;
    ack_dly = 1; dst_dly = 2;
    w_scr = 14'h0001; w_ack = 1'b0; w_dst = 1'b0; w_din = '0;

    tbl[0] = '{14'h0123, 1, 2, 1'b1, 22'h000246, 10, 24'hC3A55A};
    tbl[1] = '{14'h0123, 1, 2, 1'b0, 22'h000000, 0,  24'hC3A55A};
    tbl[2] = '{14'h3FFF, 0, 0, 1'b1, 22'h007FFE, 40, entry(14'h3FFF)};
    tbl[3] = '{14'h0000, 2, 1, 1'b1, 22'h000000, 40, entry(14'h0000)};
    tbl[4] = '{14'h2AAA, 3, 3, 1'b1, 22'h005554, 40, entry(14'h2AAA)};
    tbl[5] = '{14'h0123, 1, 2, 1'b1, 22'h000246, 10, 24'hC3A55A};
    pool   = '{14'h0123, 14'h0010, 14'h3FFF, 14'h1555, 14'h0002, 14'h0003};

    // reset state, before any clock edge
    rst = 1'b0; scr_addr = tbl[0].a;
    #1 rst = 1'b1;
    #4;
    chk("rst_req", sdram_req, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_data", scrom_data, 0);
    chk("rst_ok", data_ok, 0);
    chk("rst_err", timeout_err, 0);
    repeat (2) @(negedge clk);

    // single fills; row 0 starts at reset release
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acked.delete();
      ack_dly = tbl[i].ad; dst_dly = tbl[i].dd; scr_addr = tbl[i].a;
      if (i == 0) rst = 1'b0;
      #1;
      wait_ok(60);
      chk("tbl_latency", cyc <= tbl[i].maxlat, 1);
      chk("tbl_data", scrom_data, tbl[i].d);
      chk("tbl_nfetch", acked.size(), tbl[i].fetch ? 2 : 0);
      if (tbl[i].fetch && acked.size() == 2) begin
        chk("tbl_w0addr", acked[0], tbl[i].w0);
        chk("tbl_w1addr", acked[1], tbl[i].w0 + 22'd1);
      end
    end

    // held address: no further traffic
    acked.delete(); nhigh = 0; nbad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sdram_req) nhigh++;
      if (!data_ok)  nbad++;
    end
    chk("hold_req_cycles", nhigh, 0);
    chk("hold_notok_cycles", nbad, 0);
    chk("hold_fetches", acked.size(), 0);

    // address change while word0 is outstanding
    @(negedge clk);
    acked.delete(); ack_dly = 1; dst_dly = 3; scr_addr = 14'h0010;
    cyc = 0;
    while (acked.size() < 1 && cyc < 40) begin @(negedge clk); cyc++; end
    @(negedge clk);
    scr_addr = 14'h0011; saw_old = 1'b0;
    cyc = 0;
    while (!data_ok && cyc < 60) begin
      @(negedge clk); cyc++;
      if (scrom_data == entry(14'h0010)) saw_old = 1'b1;
    end
    chk("chg_ok", data_ok, 1);
    chk("chg_data", scrom_data, entry(14'h0011));
    chk("chg_saw_old", saw_old, 0);
    chk("chg_nfetch", acked.size(), 3);
    if (acked.size() == 3) begin
      chk("chg_a0", acked[0], 22'h20);
      chk("chg_a1", acked[1], 22'h22);
      chk("chg_a2", acked[2], 22'h23);
    end

    // random address walk
    for (int s = 0; s < 40; s++) begin
      int seg;
      seg = int'($urandom_range(1, 6));
      for (int k = 0; k < seg; k++) begin
        int hold;
        @(negedge clk);
        ack_dly = int'($urandom_range(0, 3));
        dst_dly = int'($urandom_range(0, 3));
        scr_addr = pool[$urandom_range(0, 5)];
        hold = int'($urandom_range(1, 12));
        #1;
        repeat (hold) begin
          if (data_ok) chk("rand_data", scrom_data, entry(scr_addr));
          @(negedge clk); #1;
        end
      end
      wait_ok(80);
      chk("rand_live", data_ok, 1);
      chk("rand_final", scrom_data, entry(scr_addr));
    end

    // ack withheld past TIMEOUT
    @(negedge clk);
    chk("tmo_err_pre", timeout_err, 0);
    acked.delete(); ack_dly = 60; dst_dly = 2; scr_addr = 14'h0200;
    @(negedge clk);
    nhigh = 0;
    while (sdram_req && nhigh < 100) begin nhigh++; @(negedge clk); end
    chk("tmo_req_high", nhigh, 48);
    chk("tmo_gap", sdram_req, 0);
    chk("tmo_err", timeout_err, 1);
    @(negedge clk);
    chk("tmo_reissue", sdram_req, 1);
    chk("tmo_addr", sdram_addr, 22'h400);
    ack_dly = 1;
    wait_ok(200);
    chk("tmo_data", scrom_data, entry(14'h0200));
    chk("tmo_nfetch", acked.size(), 2);

    // reset while waiting for word1
    @(negedge clk);
    acked.delete(); ack_dly = 1; dst_dly = 3; scr_addr = 14'h0321;
    cyc = 0;
    while (acked.size() < 2 && cyc < 60) begin @(negedge clk); cyc++; end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst1_req", sdram_req, 0);
    chk("rst1_ok", data_ok, 0);
    chk("rst1_data", scrom_data, 0);
    chk("rst1_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0; acked.delete();
    wait_ok(60);
    chk("rst1_refill", scrom_data, entry(14'h0321));
    chk("rst1_nfetch", acked.size(), 2);
    if (acked.size() == 2) chk("rst1_a0", acked[0], 22'h642);

    // address wrap with ROM_OFFSET near the top of SDRAM
    wait_wreq("wrap_req0");
    chk("wrap_a0", w_addr, 22'h000000);
    r0 = rom(22'h000000);
    w_ack = 1'b1; w_dst = 1'b1; w_din = r0;
    @(negedge clk); w_ack = 1'b0; w_dst = 1'b0;
    if (!w_req) wait_wreq("wrap_req1");
    chk("wrap_a1", w_addr, 22'h000001);
    r1 = rom(22'h000001);
    w_ack = 1'b1; w_dst = 1'b1; w_din = r1;
    @(negedge clk); w_ack = 1'b0; w_dst = 1'b0;
    cyc = 0;
    while (!w_ok && cyc < 20) begin @(negedge clk); cyc++; end
    chk("wrap_data", w_data, {r1[7:0], r0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not reach summary, got timeout, want finish");
    $fatal(1);
  end

endmodule
